dvp_frame_capture: RTL and testbench

- Parametrised successor to the OV7670 byte-to-pixel extractor.
- Samples an 8-bit-class DVP stream (vsync/href/p_data) and assembles BYTES_PER_PIXEL bytes into one pixel.
- Tags each pixel with x/y coordinates and emits frame/line framing pulses plus per-frame error status.
- Sits between the camera pins and the pixel FIFO / line-buffer logic, in the p_clock domain.

---
 rtl/dvp_capture_pkg.sv | 20 ++
 rtl/dvp_pixel_packer.sv | 87 ++++++++
 rtl/dvp_frame_capture.sv | 258 +++++++++++++++++++++++++
 tb/tb_dvp_frame_capture.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_capture_pkg.sv
// -----------------------------------------------------------------------------
// dvp_capture_pkg
// Shared types and constants for the DVP frame-capture block.
//   state_t          : capture FSM states (SYNC, WAIT_START, CAPTURE)
//   ERR_*            : bit positions inside frame_err
// -----------------------------------------------------------------------------
package dvp_capture_pkg;

  typedef enum logic [1:0] {
    SYNC       = 2'd0,
    WAIT_START = 2'd1,
    CAPTURE    = 2'd2
  } state_t;

  localparam int ERR_PARTIAL      = 0;  // line ended with an incomplete pixel
  localparam int ERR_COL_OVF      = 1;  // more than MAX_COLS pixels in a line
  localparam int ERR_ROW_OVF      = 2;  // more than MAX_ROWS lines in a frame
  localparam int ERR_LEN_MISMATCH = 3;  // line length differs from first line

endpackage

// File: rtl/dvp_pixel_packer.sv
// -----------------------------------------------------------------------------
// dvp_pixel_packer
// Collects BYTES_PER_PIXEL sensor bytes into one pixel word. The first byte of
// a pixel lands in the most significant lane. A completed pixel is presented
// one cycle after its last byte was sampled.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clear      : drop any partially assembled pixel (line end / idle)
//   i_restart    : current byte is byte 0 of a new line (href rising edge)
//   i_byte_en    : sample i_data this cycle
//   i_keep       : a pixel completed this cycle may be emitted
//   i_data       : sensor byte
//   o_last       : current byte completes a pixel (combinational)
//   o_partial    : bytes of an incomplete pixel are pending
//   o_valid      : one-cycle strobe for o_pixel
//   o_pixel      : assembled pixel
// -----------------------------------------------------------------------------
module dvp_pixel_packer #(
  parameter int DATA_W          = 8,
  parameter int BYTES_PER_PIXEL = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_clear,
  input  logic                              i_restart,
  input  logic                              i_byte_en,
  input  logic                              i_keep,
  input  logic [DATA_W-1:0]                 i_data,
  output logic                              o_last,
  output logic                              o_partial,
  output logic                              o_valid,
  output logic [DATA_W*BYTES_PER_PIXEL-1:0] o_pixel
);

  localparam int PIX_W = DATA_W * BYTES_PER_PIXEL;
  localparam int IDX_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_PIXEL - 1);

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx;
  logic [PIX_W-1:0] r_acc;
  logic [PIX_W-1:0] w_acc_next;
  logic [PIX_W-1:0] r_pixel;
  logic             r_valid;

  // A rising href forces the byte index back to 0 even if the previous line
  // left stale state behind.
  assign w_idx     = i_restart ? '0 : r_idx;
  assign o_last    = i_byte_en & (w_idx == LAST_IDX);
  assign o_partial = (r_idx != '0);

  // Byte k goes to lane BYTES_PER_PIXEL-1-k, i.e. lane gi takes byte index
  // BYTES_PER_PIXEL-1-gi.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_PIXEL; gi++) begin : g_lane
      localparam logic [IDX_W-1:0] LANE_IDX = IDX_W'(BYTES_PER_PIXEL - 1 - gi);
      assign w_acc_next[gi*DATA_W +: DATA_W] =
        (i_byte_en && (w_idx == LANE_IDX)) ? i_data : r_acc[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_acc   <= '0;
      r_pixel <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_clear) begin
        r_idx <= '0;
      end else if (i_byte_en) begin
        r_acc <= w_acc_next;
        r_idx <= o_last ? '0 : w_idx + 1'b1;
        if (o_last && i_keep) begin
          r_pixel <= w_acc_next;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_pixel = r_pixel;

endmodule

// File: rtl/dvp_frame_capture.sv
// -----------------------------------------------------------------------------
// dvp_frame_capture
// Samples a DVP camera stream (vsync/href/p_data), assembles pixels, tags them
// with x/y coordinates and produces frame/line framing pulses and a per-frame
// error status. All logic runs on the rising edge of p_clock.
// Optional build macro: DVP_CAPTURE_STATS_EN adds frame_count,
// last_line_pixels and last_frame_lines outputs.
// Ports:
//   p_clock, rst_n  : pixel clock, asynchronous active-low reset
//   capture_en      : capture enable, sampled only at frame start
//   vsync, href     : frame sync, line valid
//   p_data          : sensor byte
//   pixel_data      : assembled pixel
//   pixel_valid     : one-cycle strobe for pixel_data/pixel_x/pixel_y
//   pixel_x/pixel_y : pixel coordinates
//   frame_start     : pulse when a captured frame begins
//   line_done       : pulse at the end of each captured line
//   frame_done      : pulse at the end of a captured frame
//   frame_err       : error bits (see dvp_capture_pkg), valid with frame_done
// MAX_COLS and MAX_ROWS must be at least 2.
// -----------------------------------------------------------------------------
module dvp_frame_capture
  import dvp_capture_pkg::*;
#(
  parameter int DATA_W            = 8,
  parameter int BYTES_PER_PIXEL   = 2,
  parameter int MAX_COLS          = 640,
  parameter int MAX_ROWS          = 480,
  parameter int VSYNC_ACTIVE_HIGH = 1
) (
  input  logic                              p_clock,
  input  logic                              rst_n,
  input  logic                              capture_en,
  input  logic                              vsync,
  input  logic                              href,
  input  logic [DATA_W-1:0]                 p_data,
  output logic [DATA_W*BYTES_PER_PIXEL-1:0] pixel_data,
  output logic                              pixel_valid,
  output logic [$clog2(MAX_COLS)-1:0]       pixel_x,
  output logic [$clog2(MAX_ROWS)-1:0]       pixel_y,
  output logic                              frame_start,
  output logic                              line_done,
  output logic                              frame_done,
  output logic [3:0]                        frame_err
`ifdef DVP_CAPTURE_STATS_EN
  ,
  output logic [15:0]                       frame_count,
  output logic [$clog2(MAX_COLS):0]         last_line_pixels,
  output logic [$clog2(MAX_ROWS):0]         last_frame_lines
`endif
);

  localparam int X_W = $clog2(MAX_COLS);
  localparam int Y_W = $clog2(MAX_ROWS);

  // Counters carry one extra bit so they can hold MAX_COLS / MAX_ROWS exactly.
  localparam logic [X_W:0] COL_LIMIT = (X_W+1)'(MAX_COLS);
  localparam logic [Y_W:0] ROW_LIMIT = (Y_W+1)'(MAX_ROWS);

  state_t       r_state;
  state_t       w_state_next;
  logic         w_start;

  logic         r_href_q;
  logic [X_W:0] r_x;
  logic [Y_W:0] r_y;
  logic [X_W:0] r_line_cnt;    // all completed pixels of the line, incl. dropped
  logic [X_W:0] r_first_len;
  logic         r_first_seen;
  logic         r_line_active;
  logic [3:0]   r_err;
  logic [3:0]   w_err_next;

  logic [X_W-1:0] r_px;
  logic [Y_W-1:0] r_py;
  logic           r_frame_start;
  logic           r_line_done;
  logic           r_frame_done;
  logic [3:0]     r_frame_err;

  logic w_vs_act;
  logic w_cap;
  logic w_href_rise;
  logic w_href_fall;
  logic w_frame_end;
  logic w_line_end;
  logic w_line_begin;
  logic w_row_ovf;
  logic w_byte_en;
  logic w_keep;
  logic w_pix_last;
  logic w_partial;

  assign w_vs_act    = (VSYNC_ACTIVE_HIGH != 0) ? vsync : ~vsync;
  assign w_cap       = (r_state == CAPTURE);
  assign w_href_rise = href & ~r_href_q;
  assign w_href_fall = ~href & r_href_q;

  // Entering blanking while a line is open closes that line in the same
  // cycle, so line_done and frame_done can coincide.
  assign w_frame_end  = w_cap & w_vs_act;
  assign w_line_end   = w_cap & r_line_active & (w_vs_act | w_href_fall);
  assign w_line_begin = w_cap & ~w_vs_act & w_href_rise;
  assign w_row_ovf    = w_line_begin & (r_y == ROW_LIMIT);
  assign w_byte_en    = w_cap & ~w_vs_act & href &
                        (r_line_active | (w_line_begin & ~w_row_ovf));
  assign w_keep       = (r_x < COL_LIMIT);

  dvp_pixel_packer #(
    .DATA_W          (DATA_W),
    .BYTES_PER_PIXEL (BYTES_PER_PIXEL)
  ) u_packer (
    .clk       (p_clock),
    .rst_n     (rst_n),
    .i_clear   (w_line_end | ~w_cap),
    .i_restart (w_line_begin),
    .i_byte_en (w_byte_en),
    .i_keep    (w_keep),
    .i_data    (p_data),
    .o_last    (w_pix_last),
    .o_partial (w_partial),
    .o_valid   (pixel_valid),
    .o_pixel   (pixel_data)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      SYNC: begin
        // Only a full blanking period proves we are at a frame boundary.
        if (w_vs_act) w_state_next = WAIT_START;
      end
      WAIT_START: begin
        if (!w_vs_act) begin
          if (capture_en) begin
            w_state_next = CAPTURE;
            w_start      = 1'b1;
          end else begin
            w_state_next = SYNC;
          end
        end
      end
      CAPTURE: begin
        if (w_vs_act) w_state_next = WAIT_START;
      end
      default: w_state_next = SYNC;
    endcase
  end

  // ---------------------------------------------------------------- errors
  always_comb begin
    w_err_next = r_err;
    if (w_line_end && w_partial)                w_err_next[ERR_PARTIAL]      = 1'b1;
    if (w_pix_last && !w_keep)                  w_err_next[ERR_COL_OVF]      = 1'b1;
    if (w_row_ovf)                              w_err_next[ERR_ROW_OVF]      = 1'b1;
    if (w_line_end && r_first_seen &&
        (r_line_cnt != r_first_len))            w_err_next[ERR_LEN_MISMATCH] = 1'b1;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_href_q      <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_cnt    <= '0;
      r_first_len   <= '0;
      r_first_seen  <= 1'b0;
      r_line_active <= 1'b0;
      r_err         <= '0;
      r_px          <= '0;
      r_py          <= '0;
      r_frame_start <= 1'b0;
      r_line_done   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_err   <= '0;
    end else begin
      r_href_q      <= href;
      r_frame_start <= w_start;
      r_line_done   <= w_line_end;
      r_frame_done  <= w_frame_end;
      if (!w_cap) begin
        r_x           <= '0;
        r_y           <= '0;
        r_line_cnt    <= '0;
        r_first_seen  <= 1'b0;
        r_line_active <= 1'b0;
        r_err         <= '0;
      end else begin
        r_err <= w_err_next;
        if (w_frame_end) r_frame_err <= w_err_next;
        if (w_line_end) begin
          r_line_active <= 1'b0;
          r_x           <= '0;
          r_line_cnt    <= '0;
          r_y           <= r_y + 1'b1;
          if (!r_first_seen) begin
            r_first_seen <= 1'b1;
            r_first_len  <= r_line_cnt;
          end
        end else begin
          if (w_line_begin && !w_row_ovf) r_line_active <= 1'b1;
          if (w_pix_last) begin
            if (r_line_cnt != '1) r_line_cnt <= r_line_cnt + 1'b1;
            if (w_keep) begin
              r_px <= r_x[X_W-1:0];
              r_py <= r_y[Y_W-1:0];
              r_x  <= r_x + 1'b1;
            end
          end
        end
      end
    end
  end

  assign pixel_x     = r_px;
  assign pixel_y     = r_py;
  assign frame_start = r_frame_start;
  assign line_done   = r_line_done;
  assign frame_done  = r_frame_done;
  assign frame_err   = r_frame_err;

`ifdef DVP_CAPTURE_STATS_EN
  logic [15:0]  r_frame_count;
  logic [X_W:0] r_last_line_pixels;
  logic [Y_W:0] r_last_frame_lines;

  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_count      <= '0;
      r_last_line_pixels <= '0;
      r_last_frame_lines <= '0;
    end else begin
      if (w_line_end) r_last_line_pixels <= r_line_cnt;
      if (w_frame_end) begin
        r_frame_count      <= r_frame_count + 16'd1;
        // A line closed by the vsync edge itself still counts.
        r_last_frame_lines <= w_line_end ? r_y + 1'b1 : r_y;
      end
    end
  end

  assign frame_count      = r_frame_count;
  assign last_line_pixels = r_last_line_pixels;
  assign last_frame_lines = r_last_frame_lines;
`endif

endmodule

// File: tb/tb_dvp_frame_capture.sv
module tb_dvp_frame_capture;

  logic       p_clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       capture_en = 1'b0;
  logic       cap3 = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] p_data = 8'h00;

  // DUT A: 2 bytes/pixel, 4x4 limits so overflow cases are short.
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic [1:0]  pixel_x;
  logic [1:0]  pixel_y;
  logic        frame_start, line_done, frame_done;
  logic [3:0]  frame_err;

  // DUT B: 3 bytes/pixel, default limits.
  logic [23:0] pixel_data3;
  logic        pixel_valid3;
  logic [9:0]  pixel_x3;
  logic [8:0]  pixel_y3;
  logic        frame_start3, line_done3, frame_done3;
  logic [3:0]  frame_err3;

`ifdef DVP_CAPTURE_STATS_EN
  logic [15:0] frame_count, frame_count3;
  logic [2:0]  last_line_pixels;
  logic [2:0]  last_frame_lines;
  logic [10:0] last_line_pixels3;
  logic [9:0]  last_frame_lines3;
`endif

  dvp_frame_capture #(
    .DATA_W(8), .BYTES_PER_PIXEL(2), .MAX_COLS(4), .MAX_ROWS(4), .VSYNC_ACTIVE_HIGH(1)
  ) u_dut (
    .p_clock(p_clock), .rst_n(rst_n), .capture_en(capture_en), .vsync(vsync),
    .href(href), .p_data(p_data), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
    .line_done(line_done), .frame_done(frame_done), .frame_err(frame_err)
`ifdef DVP_CAPTURE_STATS_EN
    , .frame_count(frame_count), .last_line_pixels(last_line_pixels),
    .last_frame_lines(last_frame_lines)
`endif
  );

  dvp_frame_capture #(
    .DATA_W(8), .BYTES_PER_PIXEL(3), .MAX_COLS(640), .MAX_ROWS(480), .VSYNC_ACTIVE_HIGH(1)
  ) u_dut3 (
    .p_clock(p_clock), .rst_n(rst_n), .capture_en(cap3), .vsync(vsync),
    .href(href), .p_data(p_data), .pixel_data(pixel_data3), .pixel_valid(pixel_valid3),
    .pixel_x(pixel_x3), .pixel_y(pixel_y3), .frame_start(frame_start3),
    .line_done(line_done3), .frame_done(frame_done3), .frame_err(frame_err3)
`ifdef DVP_CAPTURE_STATS_EN
    , .frame_count(frame_count3), .last_line_pixels(last_line_pixels3),
    .last_frame_lines(last_frame_lines3)
`endif
  );

  always #5 p_clock = ~p_clock;

  int n_checks = 0;
  int n_pass = 0;

  // Event counters for the frame under test.
  int n_pix, n_ld, n_fs, n_fd, n_both;
  int n_pix3, n_ld3, n_fs3, n_fd3;
  int exp_x, exp_y, exp_x3;
  logic [3:0] last_err, last_err3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_counts();
    n_pix = 0; n_ld = 0; n_fs = 0; n_fd = 0; n_both = 0;
    n_pix3 = 0; n_ld3 = 0; n_fs3 = 0; n_fd3 = 0;
  endtask

  // Observe outputs at the falling edge, one transaction line per event.
  task automatic sample();
    if (!rst_n) return;
    if (frame_start) begin n_fs++; exp_x = 0; exp_y = 0; end
    if (pixel_valid) begin
      $display("A pixel %h x=%0d y=%0d", pixel_data, pixel_x, pixel_y);
      n_pix++;
      check("pix_data", 32'(pixel_data), 32'h1234);
      check("pix_xy", {28'd0, pixel_x, pixel_y}, {28'd0, 2'(exp_x), 2'(exp_y)});
      exp_x++;
    end
    if (line_done) begin n_ld++; exp_x = 0; exp_y++; end
    if (frame_done) begin
      $display("A frame_done err=%b line_done=%0b", frame_err, line_done);
      n_fd++; last_err = frame_err;
      if (line_done) n_both++;
    end
    if (frame_start3) begin n_fs3++; exp_x3 = 0; end
    if (pixel_valid3) begin
      $display("B pixel %h x=%0d y=%0d", pixel_data3, pixel_x3, pixel_y3);
      n_pix3++;
      check("pix3_data", 32'(pixel_data3), 32'h00AABBCC);
      check("pix3_xy", {13'd0, pixel_x3, pixel_y3}, {13'd0, 10'(exp_x3), 9'd0});
      exp_x3++;
    end
    if (line_done3) n_ld3++;
    if (frame_done3) begin n_fd3++; last_err3 = frame_err3; end
  endtask

  task automatic tick();
    @(posedge p_clock);
    @(negedge p_clock);
    sample();
  endtask

  function automatic logic [7:0] byte_val(input int i, input bit pat3);
    if (pat3) begin
      case (i % 3)
        0:       return 8'hAA;
        1:       return 8'hBB;
        default: return 8'hCC;
      endcase
    end
    return ((i % 2) == 0) ? 8'h12 : 8'h34;
  endfunction

  task automatic drive_line(input int nbytes, input bit pat3);
    href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      p_data = byte_val(i, pat3);
      tick();
    end
    href = 1'b0;
    p_data = 8'h00;
    repeat (3) tick();
  endtask

  task automatic run_frame(input logic cap, input logic c3, input int lines,
                           input int first_b, input int other_b, input bit pat3);
    clear_counts();
    capture_en = cap;
    cap3 = c3;
    vsync = 1'b1; tick(); tick();
    vsync = 1'b0; tick(); tick();
    for (int l = 0; l < lines; l++) drive_line((l == 0) ? first_b : other_b, pat3);
    vsync = 1'b1;
    repeat (4) tick();
  endtask

  typedef struct {
    logic       cap;
    int         lines;
    int         first_b;
    int         other_b;
    int         exp_pix;
    int         exp_ld;
    int         exp_fs;
    logic [3:0] exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b1, 4, 8,  8, 16, 4, 1, 4'b0000};  // 4x4 frame of 0x1234
    vecs[1] = '{1'b1, 1, 7,  7,  3, 1, 1, 4'b0001};  // 7-byte line, partial
    vecs[2] = '{1'b1, 2, 12, 8,  8, 2, 1, 4'b1010};  // 6 px > MAX_COLS, then 4 px
    vecs[3] = '{1'b1, 5, 8,  8, 16, 4, 1, 4'b0100};  // 5th line > MAX_ROWS
    vecs[4] = '{1'b1, 2, 8,  6,  7, 2, 1, 4'b1000};  // 4 px then 3 px
    vecs[5] = '{1'b0, 2, 8,  8,  0, 0, 0, 4'b0000};  // capture disabled
    vecs[6] = '{1'b1, 1, 8,  8,  4, 1, 1, 4'b0000};  // re-enabled next frame

    exp_x = 0; exp_y = 0; exp_x3 = 0;
    last_err = '0; last_err3 = '0;
    clear_counts();

    // Reset state.
    repeat (3) tick();
    check("reset_outputs",
          {4'd0, pixel_data, pixel_valid, pixel_x, pixel_y, frame_start, line_done,
           frame_done, frame_err}, 32'd0);

    // Release reset in the middle of an active frame: must stay silent.
    rst_n = 1'b1;
    capture_en = 1'b1;
    for (int l = 0; l < 3; l++) drive_line(8, 1'b0);
    check("midframe_pixels", 32'(n_pix), 32'd0);
    check("midframe_fstart", 32'(n_fs), 32'd0);

    // Table of whole frames.
    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].cap, 1'b0, vecs[v].lines, vecs[v].first_b, vecs[v].other_b, 1'b0);
      $display("vec %0d: pix=%0d ld=%0d fs=%0d fd=%0d err=%b", v, n_pix, n_ld, n_fs, n_fd, last_err);
      check($sformatf("v%0d_pixels", v), 32'(n_pix), 32'(vecs[v].exp_pix));
      check($sformatf("v%0d_line_done", v), 32'(n_ld), 32'(vecs[v].exp_ld));
      check($sformatf("v%0d_frame_start", v), 32'(n_fs), 32'(vecs[v].exp_fs));
      check($sformatf("v%0d_frame_done", v), 32'(n_fd), 32'(vecs[v].exp_fs));
      if (vecs[v].exp_fs != 0)
        check($sformatf("v%0d_frame_err", v), 32'(last_err), 32'(vecs[v].exp_err));
    end

    // vsync goes active while href is high, mid-pixel.
    clear_counts();
    capture_en = 1'b1;
    vsync = 1'b1; tick();
    vsync = 1'b0; tick(); tick();
    href = 1'b1;
    p_data = 8'h12; tick();
    p_data = 8'h34; tick();
    p_data = 8'h12; tick();
    vsync = 1'b1; p_data = 8'h34; tick();
    href = 1'b0; p_data = 8'h00;
    repeat (4) tick();
    check("vsh_pixels", 32'(n_pix), 32'd1);
    check("vsh_line_done", 32'(n_ld), 32'd1);
    check("vsh_frame_done", 32'(n_fd), 32'd1);
    check("vsh_same_cycle", 32'(n_both), 32'd1);
    check("vsh_frame_err", 32'(last_err), 32'b0001);

    // Reset pulse during the next frame.
    clear_counts();
    vsync = 1'b0; tick(); tick();
    href = 1'b1;
    for (int i = 0; i < 4; i++) begin p_data = byte_val(i, 1'b0); tick(); end
    rst_n = 1'b0;
    #1;
    check("rstpulse_outputs",
          {4'd0, pixel_data, pixel_valid, pixel_x, pixel_y, frame_start, line_done,
           frame_done, frame_err}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    clear_counts();
    for (int i = 0; i < 4; i++) begin p_data = byte_val(i, 1'b0); tick(); end
    href = 1'b0; p_data = 8'h00;
    repeat (3) tick();
    vsync = 1'b1;
    repeat (4) tick();
    check("rstpulse_silent", 32'(n_pix + n_fs + n_fd + n_ld), 32'd0);
    run_frame(1'b1, 1'b0, 1, 8, 8, 1'b0);
    check("resync_pixels", 32'(n_pix), 32'd4);
    check("resync_frame_done", 32'(n_fd), 32'd1);
    check("resync_frame_err", 32'(last_err), 32'd0);

    // Three bytes per pixel: frame 1 disabled, frame 2 enabled.
    run_frame(1'b0, 1'b0, 1, 6, 6, 1'b1);
    check("b3_f1_pixels", 32'(n_pix3), 32'd0);
    check("b3_f1_fstart", 32'(n_fs3), 32'd0);
    run_frame(1'b0, 1'b1, 1, 6, 6, 1'b1);
    check("b3_f2_pixels", 32'(n_pix3), 32'd2);
    check("b3_f2_fstart", 32'(n_fs3), 32'd1);
    check("b3_f2_line_done", 32'(n_ld3), 32'd1);
    check("b3_f2_frame_done", 32'(n_fd3), 32'd1);
    check("b3_f2_frame_err", 32'(last_err3), 32'd0);
`ifdef DVP_CAPTURE_STATS_EN
    check("b3_frame_count", 32'(frame_count3), 32'd1);
    check("b3_last_line_pixels", 32'(last_line_pixels3), 32'd2);
    check("b3_last_frame_lines", 32'(last_frame_lines3), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
